// File: rtl/atomrvcore_decode_stage.sv
// RV32I/RV32E decode stage: register file with write-back bypass, immediate and
// ALU-op decode, one registered output bundle with load-use bubble and flush.
module atomrvcore_decode_stage #(
    parameter int DATAWIDTH   = 32,
    parameter int REGISTERS   = 32,
    parameter int ALUOP_WIDTH = 6,
    parameter bit BYPASS_EN   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [31:0]            instr_i,
    input  logic [DATAWIDTH-1:0]   pc_i,
    input  logic                   wb_en_i,
    input  logic [4:0]             wb_rd_i,
    input  logic [DATAWIDTH-1:0]   wb_data_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATAWIDTH-1:0]   pc_o,
    output logic [DATAWIDTH-1:0]   operand_a_o,
    output logic [DATAWIDTH-1:0]   operand_b_o,
    output logic [DATAWIDTH-1:0]   rs2_data_o,
    output logic [DATAWIDTH-1:0]   immed_o,
    output logic [4:0]             rd_o,
    output logic [ALUOP_WIDTH-1:0] alu_op_o,
    output logic [7:0]             ctrl_o,
    output logic                   illegal_o
);
    localparam int RAW = $clog2(REGISTERS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

    state_t                 r_state, w_state_next;
    logic                   r_valid;
    logic [31:0]            r_instr;
    logic [DATAWIDTH-1:0]   r_pc, r_opa, r_opb, r_rs2d, r_imm;
    logic [4:0]             r_rd;
    logic [ALUOP_WIDTH-1:0] r_alu;
    logic [7:0]             r_ctrl;
    logic                   r_illegal;
    logic [DATAWIDTH-1:0]   r_regs [REGISTERS];

    logic [31:0]          w_instr;
    logic [DATAWIDTH-1:0] w_pc, w_rs1_val, w_rs2_val, w_imm, w_opa, w_opb;
    logic [4:0]           w_rs1, w_rs2, w_rd, w_alu;
    logic [2:0]           w_f3;
    logic [6:0]           w_f7;
    logic [31:0]          w_imm32;
    logic [7:0]           w_ctrl;
    logic                 w_illegal, w_use_rs1, w_use_rs2, w_use_rd;
    logic                 w_sel_a_pc, w_sel_a_zero, w_sel_b_rs2;
    logic                 w_interlock, w_xfer_in, w_hazard;

    function automatic logic in_range(input logic [4:0] idx);
        return (REGISTERS > 16) || !idx[4];
    endfunction

    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'd0:    return 5'd1;
            3'd1:    return 5'd2;
            3'd2:    return 5'd3;
            3'd3:    return 5'd4;
            3'd4:    return 5'd5;
            3'd5:    return 5'd6;
            3'd6:    return 5'd8;
            default: return 5'd9;
        endcase
    endfunction

    // A bubbled instruction is already held in r_instr; during the bubble it is
    // re-decoded so its operands pick up the load result arriving on write-back.
    assign w_instr = (r_state == ST_BUBBLE) ? r_instr : instr_i;
    assign w_pc    = (r_state == ST_BUBBLE) ? r_pc : pc_i;
    assign w_rs1   = w_instr[19:15];
    assign w_rs2   = w_instr[24:20];
    assign w_rd    = w_instr[11:7];
    assign w_f3    = w_instr[14:12];
    assign w_f7    = w_instr[31:25];

    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0 && in_range(w_rs1)) begin
            if (BYPASS_EN && wb_en_i && wb_rd_i == w_rs1) w_rs1_val = wb_data_i;
            else                                          w_rs1_val = r_regs[w_rs1[RAW-1:0]];
        end
        if (w_rs2 != 5'd0 && in_range(w_rs2)) begin
            if (BYPASS_EN && wb_en_i && wb_rd_i == w_rs2) w_rs2_val = wb_data_i;
            else                                          w_rs2_val = r_regs[w_rs2[RAW-1:0]];
        end
    end

    always_comb begin
        w_ctrl       = '0;
        w_alu        = '0;
        w_illegal    = 1'b0;
        w_imm32      = '0;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        w_use_rd     = 1'b0;
        w_sel_a_pc   = 1'b0;
        w_sel_a_zero = 1'b0;
        w_sel_b_rs2  = 1'b0;
        case (w_instr[6:0])
            OP_LUI: begin
                w_ctrl = 8'h41; w_imm32 = {w_instr[31:12], 12'b0};
                w_sel_a_zero = 1'b1; w_use_rd = 1'b1;
            end
            OP_AUIPC: begin
                w_ctrl = 8'h81; w_imm32 = {w_instr[31:12], 12'b0};
                w_sel_a_pc = 1'b1; w_use_rd = 1'b1;
            end
            OP_JAL: begin
                w_ctrl = 8'h11; w_alu = 5'd17; w_sel_a_pc = 1'b1; w_use_rd = 1'b1;
                w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                w_ctrl = 8'h21; w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_illegal = (w_f3 != 3'd0);
            end
            OP_BRANCH: begin
                w_ctrl = 8'h08; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_sel_b_rs2 = 1'b1;
                w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
                case (w_f3)
                    3'd0:    w_alu = 5'd11;
                    3'd1:    w_alu = 5'd12;
                    3'd4:    w_alu = 5'd13;
                    3'd5:    w_alu = 5'd14;
                    3'd6:    w_alu = 5'd15;
                    3'd7:    w_alu = 5'd16;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_ctrl = 8'h03; w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_illegal = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
            end
            OP_STORE: begin
                w_ctrl = 8'h04; w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_illegal = (w_f3 > 3'd2);
            end
            OP_IMM: begin
                w_ctrl = 8'h01; w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_alu = alu_base(w_f3);
                if (w_f3 == 3'd1)      w_illegal = (w_f7 != 7'h00);
                else if (w_f3 == 3'd5) begin
                    if (w_f7 == 7'h20)      w_alu = 5'd7;
                    else if (w_f7 != 7'h00) w_illegal = 1'b1;
                end
            end
            OP_REG: begin
                w_ctrl = 8'h01; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
                w_sel_b_rs2 = 1'b1;
                if (w_f7 == 7'h00)                       w_alu = alu_base(w_f3);
                else if (w_f7 == 7'h20 && w_f3 == 3'd0) w_alu = 5'd10;
                else if (w_f7 == 7'h20 && w_f3 == 3'd5) w_alu = 5'd7;
                else                                     w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if ((w_use_rs1 && !in_range(w_rs1)) || (w_use_rs2 && !in_range(w_rs2)) ||
            (w_use_rd && !in_range(w_rd)))
            w_illegal = 1'b1;
        if (w_illegal) begin
            w_ctrl = '0;
            w_alu  = '0;
        end
    end

    assign w_imm = DATAWIDTH'($signed(w_imm32));
    assign w_opa = w_sel_a_zero ? '0 : (w_sel_a_pc ? w_pc : w_rs1_val);
    assign w_opb = w_sel_b_rs2 ? w_rs2_val : w_imm;

    assign valid_o   = r_valid && (r_state == ST_RUN);
    assign ready_o   = !w_interlock && (!valid_o || ready_i);
    assign w_xfer_in = valid_i && ready_o;
    assign w_hazard  = (r_state == ST_RUN) && w_xfer_in && valid_o && ready_i &&
                       r_ctrl[1] && (r_rd != 5'd0) &&
                       ((w_rs1 == r_rd) || (w_use_rs2 && w_rs2 == r_rd));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= ST_RUN;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_interlock  = 1'b0;
        case (r_state)
            ST_RUN:    if (w_hazard) w_state_next = ST_BUBBLE;
            ST_BUBBLE: begin
                w_interlock  = 1'b1;
                w_state_next = ST_RUN;
            end
            default:   w_state_next = ST_RUN;
        endcase
        if (flush_i) w_state_next = ST_RUN;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc      <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_rs2d    <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_alu     <= '0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            for (int unsigned i = 0; i < REGISTERS; i++) r_regs[i] <= '0;
        end else begin
            if (wb_en_i && wb_rd_i != 5'd0 && in_range(wb_rd_i))
                r_regs[wb_rd_i[RAW-1:0]] <= wb_data_i;
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (r_state == ST_BUBBLE || w_xfer_in) begin
                r_valid   <= 1'b1;
                r_instr   <= w_instr;
                r_pc      <= w_pc;
                r_opa     <= w_opa;
                r_opb     <= w_opb;
                r_rs2d    <= w_rs2_val;
                r_imm     <= w_imm;
                r_rd      <= w_rd;
                r_alu     <= ALUOP_WIDTH'(w_alu);
                r_ctrl    <= w_ctrl;
                r_illegal <= w_illegal;
            end else if (valid_o && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pc_o        = r_pc;
    assign operand_a_o = r_opa;
    assign operand_b_o = r_opb;
    assign rs2_data_o  = r_rs2d;
    assign immed_o     = r_imm;
    assign rd_o        = r_rd;
    assign alu_op_o    = r_alu;
    assign ctrl_o      = r_ctrl;
    assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_atomrvcore_decode_stage.sv
// Directed bench for atomrvcore_decode_stage: an RV32I instance plus an RV32E
// instance sharing the same stimulus, checked against hand-computed values.
module tb_atomrvcore_decode_stage;
    logic        clk, rst_ni, valid_i, ready_i, wb_en_i, flush_i;
    logic [31:0] instr_i, pc_i, wb_data_i;
    logic [4:0]  wb_rd_i;

    logic        ready_o, valid_o, illegal_o;
    logic [31:0] pc_o, operand_a_o, operand_b_o, rs2_data_o, immed_o;
    logic [4:0]  rd_o;
    logic [5:0]  alu_op_o;
    logic [7:0]  ctrl_o;

    logic        e_ready_o, e_valid_o, e_illegal_o;
    logic [31:0] e_pc_o, e_operand_a_o, e_operand_b_o, e_rs2_data_o, e_immed_o;
    logic [4:0]  e_rd_o;
    logic [5:0]  e_alu_op_o;
    logic [7:0]  e_ctrl_o;

    int n_total = 0;
    int n_bad   = 0;

    atomrvcore_decode_stage #(
        .DATAWIDTH(32), .REGISTERS(32), .ALUOP_WIDTH(6), .BYPASS_EN(1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .pc_o(pc_o), .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .rs2_data_o(rs2_data_o), .immed_o(immed_o), .rd_o(rd_o), .alu_op_o(alu_op_o),
        .ctrl_o(ctrl_o), .illegal_o(illegal_o)
    );

    atomrvcore_decode_stage #(
        .DATAWIDTH(32), .REGISTERS(16), .ALUOP_WIDTH(6), .BYPASS_EN(1)
    ) u_dut_e (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(e_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .flush_i(flush_i), .valid_o(e_valid_o), .ready_i(ready_i),
        .pc_o(e_pc_o), .operand_a_o(e_operand_a_o), .operand_b_o(e_operand_b_o),
        .rs2_data_o(e_rs2_data_o), .immed_o(e_immed_o), .rd_o(e_rd_o), .alu_op_o(e_alu_op_o),
        .ctrl_o(e_ctrl_o), .illegal_o(e_illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        valid_i = 1'b1;
        instr_i = ins;
        pc_i    = pc;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; wb_en_i = 1'b0; flush_i = 1'b0;
        instr_i = '0; pc_i = '0; wb_rd_i = '0; wb_data_i = '0;

        // reset state
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_ctrl", 32'(ctrl_o), 32'h0);
        chk("rst_opa", operand_a_o, 32'h0);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", 32'(ready_o), 32'h1);

        // write x5 = 0x10, then ADDI x6,x5,-1
        wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h10;
        tick();
        wb_en_i = 1'b0;
        offer(32'hFFF28313, 32'h100);
        tick();
        valid_i = 1'b0;
        chk("addi_valid", 32'(valid_o), 32'h1);
        chk("addi_opa", operand_a_o, 32'h10);
        chk("addi_opb", operand_b_o, 32'hFFFFFFFF);
        chk("addi_alu", 32'(alu_op_o), 32'd1);
        chk("addi_rd", 32'(rd_o), 32'd6);
        chk("addi_ctrl", 32'(ctrl_o), 32'h01);
        chk("addi_pc", pc_o, 32'h100);
        tick();
        chk("drain_valid", 32'(valid_o), 32'h0);

        // backpressure: hold for 3 cycles, then next instruction loads
        ready_i = 1'b0;
        offer(32'hFFF28313, 32'h200);
        tick();
        offer(enc_i(12'h00F, 5'd5, 3'd4, 5'd9, 7'b0010011), 32'h204);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(ready_o), 32'h0);
            chk("hold_valid", 32'(valid_o), 32'h1);
            chk("hold_pc", pc_o, 32'h200);
            chk("hold_opa", operand_a_o, 32'h10);
            tick();
        end
        ready_i = 1'b1;
        #1;
        chk("release_ready", 32'(ready_o), 32'h1);
        tick();
        chk("xori_pc", pc_o, 32'h204);
        chk("xori_alu", 32'(alu_op_o), 32'd5);
        chk("xori_opb", operand_b_o, 32'hF);
        valid_i = 1'b0;
        tick();
        chk("xori_drain", 32'(valid_o), 32'h0);

        // load-use: LW x1,0(x2) then ADD x3,x1,x1 -> one bubble
        offer(enc_i(12'h000, 5'd2, 3'd2, 5'd1, 7'b0000011), 32'h300);
        tick();
        chk("lw_ctrl", 32'(ctrl_o), 32'h03);
        chk("lw_alu", 32'(alu_op_o), 32'd0);
        offer(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd3), 32'h304);
        tick();
        offer(enc_i(12'h007, 5'd0, 3'd0, 5'd10, 7'b0010011), 32'h308);
        wb_en_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h55;
        #1;
        chk("bubble_valid", 32'(valid_o), 32'h0);
        chk("bubble_ready", 32'(ready_o), 32'h0);
        tick();
        wb_en_i = 1'b0;
        chk("lu_valid", 32'(valid_o), 32'h1);
        chk("lu_pc", pc_o, 32'h304);
        chk("lu_opa", operand_a_o, 32'h55);
        chk("lu_opb", operand_b_o, 32'h55);
        chk("lu_rd", 32'(rd_o), 32'd3);
        tick();
        chk("after_bubble_pc", pc_o, 32'h308);
        chk("after_bubble_imm", immed_o, 32'h7);
        chk("after_bubble_opa", operand_a_o, 32'h0);
        offer(enc_i(12'h000, 5'd2, 3'd2, 5'd1, 7'b0000011), 32'h400);
        tick();
        offer(enc_r(7'h00, 5'd4, 5'd4, 3'd0, 5'd3), 32'h404);
        #1;
        chk("nohaz_ready", 32'(ready_o), 32'h1);
        tick();
        chk("nohaz_valid", 32'(valid_o), 32'h1);
        chk("nohaz_pc", pc_o, 32'h404);
        valid_i = 1'b0;
        tick();

        // same-cycle bypass and x0 handling
        wb_en_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'hDEADBEEF;
        offer(enc_r(7'h20, 5'd0, 5'd7, 3'd0, 5'd8), 32'h500);
        tick();
        chk("sub_opa", operand_a_o, 32'hDEADBEEF);
        chk("sub_alu", 32'(alu_op_o), 32'd10);
        chk("sub_opb", operand_b_o, 32'h0);
        wb_rd_i = 5'd0; wb_data_i = 32'h1234;
        offer(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd11), 32'h504);
        tick();
        chk("x0_bypass", operand_a_o, 32'h0);
        wb_en_i = 1'b0;
        offer(enc_r(7'h00, 5'd7, 5'd0, 3'd0, 5'd12), 32'h508);
        tick();
        chk("x0_read", operand_a_o, 32'h0);
        chk("x7_read", operand_b_o, 32'hDEADBEEF);
        chk("x7_store", rs2_data_o, 32'hDEADBEEF);
        valid_i = 1'b0;
        tick();

        // flush drops held and incoming
        ready_i = 1'b0;
        offer(enc_i(12'h001, 5'd0, 3'd0, 5'd13, 7'b0010011), 32'h600);
        tick();
        chk("flush_held", 32'(valid_o), 32'h1);
        offer(enc_i(12'h002, 5'd0, 3'd0, 5'd14, 7'b0010011), 32'h604);
        flush_i = 1'b1;
        tick();
        chk("flush_valid", 32'(valid_o), 32'h0);
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("flush_ready", 32'(ready_o), 32'h1);
        tick();
        chk("flush_dropped", 32'(valid_o), 32'h0);
        chk("flush_pc", pc_o, 32'h600);

        // other formats
        offer({20'hABCDE, 5'd15, 7'b0110111}, 32'h700);
        tick();
        chk("lui_opa", operand_a_o, 32'h0);
        chk("lui_opb", operand_b_o, 32'hABCDE000);
        chk("lui_ctrl", 32'(ctrl_o), 32'h41);
        offer(enc_s(12'd12, 5'd5, 5'd1, 3'd2), 32'h704);
        tick();
        chk("sw_opa", operand_a_o, 32'h55);
        chk("sw_opb", operand_b_o, 32'hC);
        chk("sw_rs2", rs2_data_o, 32'h10);
        chk("sw_ctrl", 32'(ctrl_o), 32'h04);
        offer(enc_b(13'h1FF8, 5'd5, 5'd1, 3'd1), 32'h708);
        tick();
        chk("bne_opb", operand_b_o, 32'h10);
        chk("bne_imm", immed_o, 32'hFFFFFFF8);
        chk("bne_alu", 32'(alu_op_o), 32'd12);
        chk("bne_ctrl", 32'(ctrl_o), 32'h08);
        offer(enc_j(21'd16, 5'd1), 32'h70C);
        tick();
        chk("jal_opa", operand_a_o, 32'h70C);
        chk("jal_opb", operand_b_o, 32'h10);
        chk("jal_alu", 32'(alu_op_o), 32'd17);
        chk("jal_ctrl", 32'(ctrl_o), 32'h11);

        // illegal encodings
        offer(32'h0000007F, 32'h710);
        tick();
        chk("op7f_valid", 32'(valid_o), 32'h1);
        chk("op7f_illegal", 32'(illegal_o), 32'h1);
        chk("op7f_ctrl", 32'(ctrl_o), 32'h0);
        chk("op7f_alu", 32'(alu_op_o), 32'h0);
        offer(enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd3), 32'h714);
        tick();
        chk("f7_illegal", 32'(illegal_o), 32'h1);
        offer(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd17), 32'h718);
        tick();
        chk("x17_legal_i", 32'(illegal_o), 32'h0);
        chk("x17_ctrl_i", 32'(ctrl_o), 32'h01);
        chk("x17_valid_e", 32'(e_valid_o), 32'h1);
        chk("x17_illegal_e", 32'(e_illegal_o), 32'h1);
        chk("x17_ctrl_e", 32'(e_ctrl_o), 32'h0);
        valid_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
